// File: rtl/waveform_uart_tx.sv
// waveform_uart_tx: snapshots a captured pulse record and sends it as a 69-byte 8N1 UART packet.
module waveform_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int N_SAMPLES = 32,
  parameter int SAMPLE_W = 14
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            long_trigger,
  input  logic [N_SAMPLES*SAMPLE_W-1:0]   waveform_in,
  input  logic [SAMPLE_W-1:0]             pulse_height_in,
  output logic                            uart_txd,
  output logic                            busy,
  output logic                            dropped,
  output logic [15:0]                     packets_sent
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] RL = TW'(CLKS_PER_BIT - 1);
  logic [1:0] state;
  logic [TW-1:0] timer;
  logic [2:0] bit_idx;
  logic [6:0] byte_idx, nb;
  logic [7:0] shreg, chk, nbyte;
  logic [4:0] sidx;
  logic [15:0] s16, p16;
  logic lt_q, ev, done, accept;
  logic [SAMPLE_W-1:0] snap [N_SAMPLES];
  logic [SAMPLE_W-1:0] ph_snap;
  always_comb begin
    nb = byte_idx + 7'd1;
    sidx = 5'((nb - 7'd4) >> 1);
    s16 = 16'(snap[sidx]);
    p16 = 16'(ph_snap);
    nbyte = nb == 7'd68 ? chk :
            nb >= 7'd4  ? (nb[0] ? s16[7:0] : s16[15:8]) :
            nb == 7'd3  ? p16[7:0] :
            nb == 7'd2  ? p16[15:8] :
            nb == 7'd1  ? 8'h5A : 8'hA5;
    ev = !long_trigger && lt_q;
    done = state == STOP && timer == '0 && byte_idx == 7'd68;
    accept = ev && (state == IDLE || done);
  end
  // snapshot is don't-care after reset, so it carries no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N_SAMPLES; i++) snap[i] <= waveform_in[i*SAMPLE_W +: SAMPLE_W];
      ph_snap <= pulse_height_in;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      shreg <= '0;
      chk <= '0;
      lt_q <= 1'b0;
      uart_txd <= 1'b1;
      busy <= 1'b0;
      dropped <= 1'b0;
      packets_sent <= '0;
    end else begin
      lt_q <= long_trigger;
      dropped <= ev && !accept;
      if (accept) begin
        state <= START;
        uart_txd <= 1'b0;
        busy <= 1'b1;
        timer <= RL;
        byte_idx <= '0;
        chk <= '0;
        shreg <= 8'hA5;
        if (done) packets_sent <= packets_sent + 16'd1;
      end else if (state != IDLE) begin
        if (timer != '0) timer <= timer - TW'(1);
        else begin
          timer <= RL;
          case (state)
            START: begin
              state <= DATA;
              uart_txd <= shreg[0];
              shreg <= shreg >> 1;
              bit_idx <= '0;
            end
            DATA: begin
              if (bit_idx == 3'd7) begin
                state <= STOP;
                uart_txd <= 1'b1;
              end else begin
                uart_txd <= shreg[0];
                shreg <= shreg >> 1;
                bit_idx <= bit_idx + 3'd1;
              end
            end
            default: begin
              if (done) begin
                state <= IDLE;
                busy <= 1'b0;
                packets_sent <= packets_sent + 16'd1;
              end else begin
                // checksum covers b2..b67, folded in as each byte is loaded
                state <= START;
                uart_txd <= 1'b0;
                byte_idx <= nb;
                shreg <= nbyte;
                chk <= (nb >= 7'd2 && nb <= 7'd67) ? chk + nbyte : chk;
              end
            end
          endcase
        end
      end
    end
  end
endmodule
